// File: rtl/rs_dispatch.sv
// rs_dispatch -- allocates reservation-station / ROB slots for up to two renamed
// instructions per cycle from a 16-entry free mask.
//
// Ports
//   clk                  sole clock, rising edge
//   reset                synchronous active-high reset
//   in_valid_a/b         renamed instruction A (older) / B present
//   inst_a/b             renamed instruction payload (inst_t)
//   fu_a/b               target FU: 0 = ALU0, 1 = ALU1, 2 = mem
//   phy_reg_rdy          physical register ready bits
//   free_valid/free_idx  slots released by issue ports 0..2
//   flush                discard every allocation
//   rsLine_a/b           registered entries sent to the reservation station
//   stall                combinational; upstream holds A/B while high
//   free_count           registered number of free slots (0..16)
//
// Build option
//   DISPATCH_SAME_CYCLE_FREE_EN  when defined, slots released this cycle can be
//                                allocated this cycle; otherwise from the next cycle.

package rs_dispatch_pkg;

    typedef struct packed {
        logic RegWrite;
        logic ALUSrc;
        logic MemRead;
        logic MemWrite;
        logic MemtoReg;
        logic Branch;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [5:0]  rd;
        logic [5:0]  rd_old;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  ALUCtrl;
        ctrl_t       control;
    } inst_t;

    // rsEntry
    typedef struct packed {
        logic        valid;
        logic [3:0]  robNum;
        logic [1:0]  fu;
        logic        src1rdy;
        logic        src2rdy;
        inst_t       inst;
    } rs_entry_t;

endpackage

module rs_dispatch
    import rs_dispatch_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid_a,
    input  logic            in_valid_b,
    input  inst_t           inst_a,
    input  inst_t           inst_b,
    input  logic [1:0]      fu_a,
    input  logic [1:0]      fu_b,
    input  logic [63:0]     phy_reg_rdy,
    input  logic [2:0]      free_valid,
    input  logic [2:0][3:0] free_idx,
    input  logic            flush,
    output rs_entry_t       rsLine_a,
    output rs_entry_t       rsLine_b,
    output logic            stall,
    output logic [4:0]      free_count
);

    function automatic logic [4:0] popcount16(input logic [15:0] m);
        popcount16 = '0;
        for (int i = 0; i < 16; i++)
            popcount16 = popcount16 + {4'b0000, m[i]};
    endfunction

    function automatic logic [3:0] lowest_set(input logic [15:0] m);
        lowest_set = '0;
        for (int i = 15; i >= 0; i--)
            if (m[i]) lowest_set = 4'(i);
    endfunction

    logic [15:0] mask_q, mask_d;
    logic [4:0]  free_count_q, free_count_d;
    rs_entry_t   rs_a_q, rs_a_d;
    rs_entry_t   rs_b_q, rs_b_d;

    logic [15:0] rel_mask;
    logic [15:0] avail;
    logic [4:0]  avail_count;
    logic [4:0]  need;
    logic [3:0]  idx0, idx1, idx_a, idx_b;
    logic [15:0] alloc;

    // Duplicate or already-free indices collapse harmlessly in the OR.
    always_comb begin
        rel_mask = '0;
        for (int k = 0; k < 3; k++)
            if (free_valid[k]) rel_mask[free_idx[k]] = 1'b1;
    end

`ifdef DISPATCH_SAME_CYCLE_FREE_EN
    assign avail       = mask_q | rel_mask;
    assign avail_count = popcount16(avail);
`else
    assign avail       = mask_q;
    assign avail_count = free_count_q;
`endif

    assign need  = {4'b0000, in_valid_a} + {4'b0000, in_valid_b};
    assign stall = flush | (need > avail_count);

    assign idx0  = lowest_set(avail);
    assign idx1  = lowest_set(avail & ~(16'(1) << idx0));
    // B takes the lowest slot when A is absent.
    assign idx_a = idx0;
    assign idx_b = in_valid_a ? idx1 : idx0;

    always_comb begin
        alloc  = '0;
        rs_a_d = '0;
        rs_b_d = '0;
        if (!stall) begin
            if (in_valid_a) begin
                rs_a_d.valid   = 1'b1;
                rs_a_d.robNum  = idx_a;
                rs_a_d.fu      = fu_a;
                rs_a_d.inst    = inst_a;
                rs_a_d.src1rdy = phy_reg_rdy[inst_a.rs1];
                rs_a_d.src2rdy = inst_a.control.ALUSrc | phy_reg_rdy[inst_a.rs2];
                alloc[idx_a]   = 1'b1;
            end
            if (in_valid_b) begin
                rs_b_d.valid   = 1'b1;
                rs_b_d.robNum  = idx_b;
                rs_b_d.fu      = fu_b;
                rs_b_d.inst    = inst_b;
                rs_b_d.src1rdy = phy_reg_rdy[inst_b.rs1];
                rs_b_d.src2rdy = inst_b.control.ALUSrc | phy_reg_rdy[inst_b.rs2];
                // A writes a register B reads: the ready bit B saw is stale.
                if (in_valid_a && inst_a.control.RegWrite && (inst_a.rd == inst_b.rs1))
                    rs_b_d.src1rdy = 1'b0;
                if (in_valid_a && inst_a.control.RegWrite && (inst_a.rd == inst_b.rs2))
                    rs_b_d.src2rdy = 1'b0;
                alloc[idx_b]   = 1'b1;
            end
        end
    end

    // Release and allocation land on the same edge; flush wins over both.
    assign mask_d       = flush ? 16'hFFFF : ((mask_q | rel_mask) & ~alloc);
    assign free_count_d = popcount16(mask_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q       <= 16'hFFFF;
            free_count_q <= 5'd16;
            rs_a_q       <= '0;
            rs_b_q       <= '0;
        end else begin
            mask_q       <= mask_d;
            free_count_q <= free_count_d;
            rs_a_q       <= rs_a_d;
            rs_b_q       <= rs_b_d;
        end
    end

    assign rsLine_a   = rs_a_q;
    assign rsLine_b   = rs_b_q;
    assign free_count = free_count_q;

endmodule

// File: tb/tb_rs_dispatch.sv
module tb_rs_dispatch;
    import rs_dispatch_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid_a, in_valid_b;
    inst_t           inst_a, inst_b;
    logic [1:0]      fu_a, fu_b;
    logic [63:0]     phy_reg_rdy;
    logic [2:0]      free_valid;
    logic [2:0][3:0] free_idx;
    logic            flush;
    rs_entry_t       rsLine_a, rsLine_b;
    logic            stall;
    logic [4:0]      free_count;

    always #5 clk = ~clk;

    rs_dispatch dut (
        .clk(clk), .reset(reset),
        .in_valid_a(in_valid_a), .in_valid_b(in_valid_b),
        .inst_a(inst_a), .inst_b(inst_b),
        .fu_a(fu_a), .fu_b(fu_b),
        .phy_reg_rdy(phy_reg_rdy),
        .free_valid(free_valid), .free_idx(free_idx),
        .flush(flush),
        .rsLine_a(rsLine_a), .rsLine_b(rsLine_b),
        .stall(stall), .free_count(free_count)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: a set of free slots as a bit array.
    bit        m_free[16];
    bit        nxt_free[16];
    logic      exp_stall;
    rs_entry_t exp_a, exp_b;
    int        exp_cnt;

    function automatic inst_t rand_inst();
        inst_t t;
        t.pc      = $urandom;
        t.opcode  = 7'($urandom);
        t.rd      = 6'($urandom);
        t.rd_old  = 6'($urandom);
        t.rs1     = 6'($urandom);
        t.rs2     = 6'($urandom);
        t.imm     = $urandom;
        t.ALUCtrl = 4'($urandom);
        t.control = ctrl_t'($urandom);
        return t;
    endfunction

    function automatic inst_t plain_inst(input logic [5:0] rd, input logic [5:0] rs1,
                                         input logic [5:0] rs2, input bit regwrite, input bit alusrc);
        inst_t t;
        t = rand_inst();
        t.rd = rd;
        t.rs1 = rs1;
        t.rs2 = rs2;
        t.control.RegWrite = regwrite;
        t.control.ALUSrc = alusrc;
        return t;
    endfunction

    function automatic rs_entry_t make_entry(input inst_t ins, input logic [1:0] fu, input int idx);
        rs_entry_t e;
        e = '0;
        e.valid   = 1'b1;
        e.robNum  = 4'(idx);
        e.fu      = fu;
        e.inst    = ins;
        e.src1rdy = phy_reg_rdy[ins.rs1];
        e.src2rdy = ins.control.ALUSrc ? 1'b1 : phy_reg_rdy[ins.rs2];
        return e;
    endfunction

    task automatic model_eval();
        bit rel[16];
        bit avail[16];
        int cnt;
        int need;
        int fl[$];
        for (int i = 0; i < 16; i++) rel[i] = 1'b0;
        for (int k = 0; k < 3; k++) if (free_valid[k]) rel[free_idx[k]] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
`ifdef DISPATCH_SAME_CYCLE_FREE_EN
            avail[i] = m_free[i] | rel[i];
`else
            avail[i] = m_free[i];
`endif
            if (avail[i]) begin
                cnt++;
                fl.push_back(i);
            end
        end
        need = int'(in_valid_a) + int'(in_valid_b);
        exp_stall = flush || (need > cnt);
        exp_a = '0;
        exp_b = '0;
        for (int i = 0; i < 16; i++) nxt_free[i] = m_free[i] | rel[i];
        if (reset || flush) begin
            for (int i = 0; i < 16; i++) nxt_free[i] = 1'b1;
        end else if (!exp_stall) begin
            if (in_valid_a) begin
                exp_a = make_entry(inst_a, fu_a, fl[0]);
                nxt_free[fl[0]] = 1'b0;
            end
            if (in_valid_b) begin
                exp_b = make_entry(inst_b, fu_b, in_valid_a ? fl[1] : fl[0]);
                nxt_free[exp_b.robNum] = 1'b0;
                if (in_valid_a && inst_a.control.RegWrite && inst_a.rd == inst_b.rs1) exp_b.src1rdy = 1'b0;
                if (in_valid_a && inst_a.control.RegWrite && inst_a.rd == inst_b.rs2) exp_b.src2rdy = 1'b0;
            end
        end
        exp_cnt = 0;
        for (int i = 0; i < 16; i++) if (nxt_free[i]) exp_cnt++;
    endtask

    task automatic tick();
        model_eval();
        for (int i = 0; i < 16; i++) m_free[i] = nxt_free[i];
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        inst_a = '0;
        inst_b = '0;
        fu_a = 2'd0;
        fu_b = 2'd0;
        phy_reg_rdy = '1;
        free_valid = '0;
        free_idx = '0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (rsLine_a !== '0) begin failures++; $display("FAIL reset_a got=%h exp=0", rsLine_a); end
        checks++; if (rsLine_b !== '0) begin failures++; $display("FAIL reset_b got=%h exp=0", rsLine_b); end
        checks++; if (free_count !== 5'd16) begin failures++; $display("FAIL reset_cnt got=%0d exp=16", free_count); end
        reset = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    endtask

    task automatic test_pair_dep();
        do_reset();
        inst_a = plain_inst(6'd10, 6'd1, 6'd2, 1'b1, 1'b0);
        inst_b = plain_inst(6'd11, 6'd10, 6'd3, 1'b0, 1'b0);
        fu_a = 2'd0;
        fu_b = 2'd2;
        in_valid_a = 1'b1;
        in_valid_b = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL pair_stall got=%0b exp=0", stall); end
        tick();
        checks++; if (rsLine_a.valid !== 1'b1 || rsLine_a.robNum !== 4'd0) begin failures++; $display("FAIL pair_rob_a got=%0b/%0d exp=1/0", rsLine_a.valid, rsLine_a.robNum); end
        checks++; if (rsLine_b.valid !== 1'b1 || rsLine_b.robNum !== 4'd1) begin failures++; $display("FAIL pair_rob_b got=%0b/%0d exp=1/1", rsLine_b.valid, rsLine_b.robNum); end
        checks++; if (rsLine_b.src1rdy !== 1'b0) begin failures++; $display("FAIL pair_dep got=%0b exp=0", rsLine_b.src1rdy); end
        checks++; if (free_count !== 5'd14) begin failures++; $display("FAIL pair_cnt got=%0d exp=14", free_count); end
        checks++; if (rsLine_b !== exp_b) begin failures++; $display("FAIL pair_entry_b got=%h exp=%h", rsLine_b, exp_b); end
        idle();
    endtask

    task automatic test_fill();
        do_reset();
        for (int p = 0; p < 7; p++) begin
            inst_a = rand_inst(); inst_b = rand_inst();
            fu_a = 2'($urandom_range(2)); fu_b = 2'($urandom_range(2));
            in_valid_a = 1'b1; in_valid_b = 1'b1;
            #1;
            checks++; if (stall !== 1'b0) begin failures++; $display("FAIL fill_stall p=%0d got=%0b exp=0", p, stall); end
            tick();
            checks++; if (rsLine_a.robNum !== 4'(2*p) || rsLine_b.robNum !== 4'(2*p+1)) begin
                failures++; $display("FAIL fill_rob p=%0d got=%0d/%0d exp=%0d/%0d", p, rsLine_a.robNum, rsLine_b.robNum, 2*p, 2*p+1);
            end
        end
        in_valid_b = 1'b0; inst_a = rand_inst();
        tick();
        checks++; if (rsLine_a.robNum !== 4'd14 || free_count !== 5'd1) begin failures++; $display("FAIL fill_15 got=%0d/%0d exp=14/1", rsLine_a.robNum, free_count); end
        in_valid_b = 1'b1; inst_a = rand_inst(); inst_b = rand_inst();
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL full_pair_stall got=%0b exp=1", stall); end
        tick();
        checks++; if (rsLine_a.valid !== 1'b0 || rsLine_b !== '0) begin failures++; $display("FAIL full_pair_out got=%0b/%h exp=0/0", rsLine_a.valid, rsLine_b); end
        in_valid_b = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL last_stall got=%0b exp=0", stall); end
        tick();
        checks++; if (rsLine_a.robNum !== 4'd15 || free_count !== 5'd0) begin failures++; $display("FAIL last_slot got=%0d/%0d exp=15/0", rsLine_a.robNum, free_count); end
        checks++; if (rsLine_a !== exp_a) begin failures++; $display("FAIL last_entry got=%h exp=%h", rsLine_a, exp_a); end
    endtask

    task automatic test_same_cycle_free();
        in_valid_a = 1'b1; in_valid_b = 1'b0; inst_a = rand_inst();
        free_valid = 3'b001; free_idx[0] = 4'd5;
        #1;
`ifdef DISPATCH_SAME_CYCLE_FREE_EN
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL scf_stall got=%0b exp=0", stall); end
        tick();
        checks++; if (rsLine_a.valid !== 1'b1 || rsLine_a.robNum !== 4'd5) begin failures++; $display("FAIL scf_slot got=%0b/%0d exp=1/5", rsLine_a.valid, rsLine_a.robNum); end
        checks++; if (free_count !== 5'd0) begin failures++; $display("FAIL scf_cnt got=%0d exp=0", free_count); end
`else
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL scf_stall got=%0b exp=1", stall); end
        tick();
        checks++; if (rsLine_a.valid !== 1'b0 || free_count !== 5'd1) begin failures++; $display("FAIL scf_hold got=%0b/%0d exp=0/1", rsLine_a.valid, free_count); end
        free_valid = 3'b000;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL scf_stall2 got=%0b exp=0", stall); end
        tick();
        checks++; if (rsLine_a.valid !== 1'b1 || rsLine_a.robNum !== 4'd5) begin failures++; $display("FAIL scf_slot got=%0b/%0d exp=1/5", rsLine_a.valid, rsLine_a.robNum); end
        checks++; if (free_count !== 5'd0) begin failures++; $display("FAIL scf_cnt got=%0d exp=0", free_count); end
`endif
        idle();
    endtask

    task automatic test_src_rdy();
        do_reset();
        phy_reg_rdy = 64'h80;
        inst_a = plain_inst(6'd20, 6'd7, 6'd9, 1'b0, 1'b1);
        inst_b = plain_inst(6'd21, 6'd9, 6'd7, 1'b0, 1'b0);
        in_valid_a = 1'b1; in_valid_b = 1'b1;
        tick();
        checks++; if (rsLine_a.src1rdy !== 1'b1 || rsLine_a.src2rdy !== 1'b1) begin failures++; $display("FAIL alusrc_a got=%0b/%0b exp=1/1", rsLine_a.src1rdy, rsLine_a.src2rdy); end
        checks++; if (rsLine_b.src1rdy !== 1'b0 || rsLine_b.src2rdy !== 1'b1) begin failures++; $display("FAIL rdy_b got=%0b/%0b exp=0/1", rsLine_b.src1rdy, rsLine_b.src2rdy); end
        in_valid_a = 1'b0;
        inst_b = plain_inst(6'd22, 6'd9, 6'd9, 1'b0, 1'b0);
        tick();
        checks++; if (rsLine_b.robNum !== 4'd2 || rsLine_a.valid !== 1'b0) begin failures++; $display("FAIL b_alone got=%0d/%0b exp=2/0", rsLine_b.robNum, rsLine_a.valid); end
        checks++; if (rsLine_b.src1rdy !== 1'b0 || rsLine_b.src2rdy !== 1'b0) begin failures++; $display("FAIL b_alone_rdy got=%0b/%0b exp=0/0", rsLine_b.src1rdy, rsLine_b.src2rdy); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        free_valid = 3'b111; free_idx[0] = 4'd0; free_idx[1] = 4'd1; free_idx[2] = 4'd2;
        in_valid_a = 1'b1; in_valid_b = 1'b1; inst_a = rand_inst(); inst_b = rand_inst();
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL flush_stall got=%0b exp=1", stall); end
        tick();
        checks++; if (rsLine_a !== '0 || rsLine_b !== '0) begin failures++; $display("FAIL flush_out got=%0b/%0b exp=0/0", rsLine_a.valid, rsLine_b.valid); end
        checks++; if (free_count !== 5'd16) begin failures++; $display("FAIL flush_cnt got=%0d exp=16", free_count); end
        idle();
    endtask

    task automatic test_reset_mid();
        in_valid_a = 1'b1; in_valid_b = 1'b1; inst_a = rand_inst(); inst_b = rand_inst();
        tick();
        reset = 1'b1;
        inst_a = rand_inst(); inst_b = rand_inst();
        free_valid = 3'b010; free_idx[1] = 4'd0;
        tick();
        checks++; if (rsLine_a !== '0 || rsLine_b !== '0) begin failures++; $display("FAIL rstmid_out got=%0b/%0b exp=0/0", rsLine_a.valid, rsLine_b.valid); end
        checks++; if (free_count !== 5'd16) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=16", free_count); end
        reset = 1'b0;
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            reset      = ($urandom_range(63) == 0);
            flush      = ($urandom_range(24) == 0);
            in_valid_a = ($urandom_range(3) != 0);
            in_valid_b = ($urandom_range(3) != 0);
            inst_a = rand_inst(); inst_b = rand_inst();
            if ($urandom_range(3) == 0) inst_b.rs1 = inst_a.rd;
            if ($urandom_range(3) == 0) inst_b.rs2 = inst_a.rd;
            fu_a = 2'($urandom_range(2)); fu_b = 2'($urandom_range(2));
            phy_reg_rdy = {$urandom, $urandom};
            for (int k = 0; k < 3; k++) begin
                free_valid[k] = ($urandom_range(2) == 0);
                free_idx[k]   = 4'($urandom_range(15));
            end
            #1;
            model_eval();
            checks++; if (stall !== exp_stall) begin failures++; $display("FAIL rnd_stall c=%0d got=%0b exp=%0b", c, stall, exp_stall); end
            tick();
            checks++; if (rsLine_a !== exp_a) begin failures++; $display("FAIL rnd_a c=%0d got=%h exp=%h", c, rsLine_a, exp_a); end
            checks++; if (rsLine_b !== exp_b) begin failures++; $display("FAIL rnd_b c=%0d got=%h exp=%h", c, rsLine_b, exp_b); end
            checks++; if (free_count !== 5'(exp_cnt)) begin failures++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, free_count, exp_cnt); end
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_free[i] = 1'b1;
        idle();
        reset = 1'b1;
        test_reset();
        test_pair_dep();
        test_fill();
        test_same_cycle_free();
        test_src_rdy();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
